// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and the decoder it feeds.
// Holds the FSM state encoding, reset/timeout defaults and the 4-bit opcode map.
package instr_fetch_unit_pkg;

    localparam logic [7:0] RESET_PC         = 8'h00;
    localparam logic [3:0] MAX_WAIT_DEFAULT = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    // Opcode lives in instruction[7:4]; register fields in [3:2] and [1:0].
    typedef enum logic [3:0] {
        OP_MOVE = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_NOT  = 4'h6,
        OP_SHL  = 4'h7,
        OP_SHR  = 4'h8,
        OP_LD   = 4'h9,
        OP_ST   = 4'hA,
        OP_J    = 4'hB,
        OP_JAL  = 4'hC,
        OP_BEQ  = 4'hD,
        OP_BNE  = 4'hE,
        OP_LI   = 4'hF
    } opcode_e;

    function automatic opcode_e opcode_of(input logic [7:0] instr);
        return opcode_e'(instr[7:4]);
    endfunction

    // Opcodes that can produce a redirect back into the fetch unit.
    function automatic logic is_flow_change(input opcode_e op);
        return (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read channel and decoder handoff channel of the fetch unit.
// master = fetch unit side, slave = memory + decoder side.
interface instr_fetch_unit_if;

    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;

    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instruction;
    logic [7:0] instr_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instr_valid,
        input  instr_ready,
        output instruction,
        output instr_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instruction,
        input  instr_pc
    );

endinterface

// File: rtl/instr_fetch_unit_watchdog.sv
// Counts memory-wait cycles without an ack; flags expiry on the cycle that
// would bring the count up to MAX_WAIT.
module fetch_watchdog #(
    parameter logic [3:0] MAX_WAIT = 4'd15
) (
    input  logic clk,
    input  logic rst,
    input  logic count,
    input  logic clear,
    output logic expired
);

    localparam logic [3:0] TERM_CNT = MAX_WAIT - 4'd1;

    logic [3:0] wait_cnt;

    // Saturates so a redirect that defers expiry still re-fires next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (clear) begin
            wait_cnt <= 4'd0;
        end else if (count && (wait_cnt != 4'hF)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign expired = count && (wait_cnt >= TERM_CNT);

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding-request instruction fetcher with redirect, decoder
// backpressure and a sticky memory-timeout fault.
//
// state | meaning
// IDLE  | no request; waits for run (blocked once fault is set)
// FETCH | request outstanding at imem_addr
// HOLD  | instruction offered to decoder, waiting for instr_ready
// DRAIN | request outstanding whose data will be discarded after a redirect
module instr_fetch_unit #(
    parameter logic [7:0] RESET_PC = instr_fetch_unit_pkg::RESET_PC,
    parameter logic [3:0] MAX_WAIT = instr_fetch_unit_pkg::MAX_WAIT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic                      redirect_valid,
    input  logic [7:0]                redirect_pc,
    output logic                      fault,
    instr_fetch_unit_if.master        bus
);

    import instr_fetch_unit_pkg::*;

    fetch_state_e state_q, state_d;
    logic [7:0]   pc_q, pc_d;
    logic [7:0]   addr_q;
    logic [7:0]   instr_q;
    logic [7:0]   instr_pc_q;
    logic         fault_q;

    logic addr_load;
    logic capture;
    logic fault_set;
    logic mem_busy;
    logic wd_count;
    logic wd_clear;
    logic wd_expired;

    assign mem_busy = (state_q == FETCH) || (state_q == DRAIN);
    assign wd_count = mem_busy && !bus.imem_ack;
    assign wd_clear = !mem_busy || bus.imem_ack;

    fetch_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .count   (wd_count),
        .clear   (wd_clear),
        .expired (wd_expired)
    );

    // Whenever FETCH is (re)entered, the new request address is pc_d.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_load = 1'b0;
        capture   = 1'b0;
        fault_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (run && !fault_q) begin
                    state_d   = FETCH;
                    addr_load = 1'b1;
                end
            end

            FETCH: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (bus.imem_ack) begin
                        state_d   = FETCH;
                        addr_load = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (bus.imem_ack) begin
                    capture = 1'b1;
                    pc_d    = pc_q + 8'd1;
                    state_d = HOLD;
                end else if (wd_expired) begin
                    fault_set = 1'b1;
                    state_d   = IDLE;
                end
            end

            HOLD: begin
                if (redirect_valid || bus.instr_ready) begin
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end
                    if (run) begin
                        state_d   = FETCH;
                        addr_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (bus.imem_ack) begin
                    state_d   = FETCH;
                    addr_load = 1'b1;
                end else if (!redirect_valid && wd_expired) begin
                    fault_set = 1'b1;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            instr_q    <= 8'h00;
            instr_pc_q <= 8'h00;
            fault_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (addr_load) begin
                addr_q <= pc_d;
            end
            if (capture) begin
                instr_q    <= bus.imem_rdata;
                instr_pc_q <= pc_q;
            end
            if (fault_set) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign bus.imem_req    = mem_busy;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = (state_q == HOLD);
    assign bus.instruction = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign fault           = fault_q;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, PC loaded on reset.
REQ-002 SHALL have parameter MAX_WAIT, default 4'd15, the number of cycles without imem_ack before a fault is raised.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port run, input, 1 bit: fetch enable.
REQ-006 SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-007 SHALL have port imem_addr, output, 8 bits: read address.
REQ-008 SHALL have port imem_ack, input, 1 bit: read complete; imem_rdata is valid in the same cycle.
REQ-009 SHALL have port imem_rdata, input, 8 bits: fetched instruction byte.
REQ-010 SHALL have port instr_valid, output, 1 bit: instruction offered to the decoder.
REQ-011 SHALL have port instr_ready, input, 1 bit: the decoder accepts the instruction.
REQ-012 SHALL have port instruction, output, 8 bits: opcode in [7:4], register fields in [3:2] and [1:0].
REQ-013 SHALL have port instr_pc, output, 8 bits: address of the offered instruction.
REQ-014 SHALL have port redirect_valid, input, 1 bit: jump/branch taken (J, Jal, beq, bne).
REQ-015 SHALL have port redirect_pc, input, 8 bits: redirect target.
REQ-016 SHALL have port fault, output, 1 bit: sticky memory timeout.

Function
REQ-017 SHALL implement states IDLE, FETCH, HOLD and DRAIN.
REQ-018 IDLE: when run=1 and fault=0, SHALL go to FETCH next cycle with imem_addr<=pc.
REQ-019 FETCH/DRAIN: imem_req SHALL be 1 and imem_addr SHALL stay stable until imem_ack.
REQ-020 FETCH with imem_ack and no redirect: SHALL latch instruction<=imem_rdata, instr_pc<=pc, pc<=pc+1 (modulo 256, so 8'hFF wraps to 8'h00), then go to HOLD; instr_valid is asserted the cycle after ack.
REQ-021 HOLD: instr_valid=1; instruction and instr_pc SHALL stay stable until instr_ready.
REQ-022 HOLD on instr_ready: SHALL go to FETCH if run=1, else IDLE.
REQ-023 Redirect SHALL take priority over every other event in all states.
- pc<=redirect_pc.
- The pending or held instruction is discarded, with no instr_valid for it.
REQ-024 Redirect in HOLD: instr_valid SHALL drop next cycle; next state is FETCH if run=1, else IDLE.
REQ-025 Redirect in FETCH with imem_ack in the same cycle: returned data SHALL be dropped; next state is FETCH at redirect_pc.
REQ-026 Redirect in FETCH without imem_ack: SHALL go to DRAIN.
REQ-027 DRAIN: on imem_ack, data SHALL be dropped and the block goes to FETCH at the current pc; a further redirect in DRAIN only updates pc.
REQ-028 Redirect in IDLE SHALL only update pc.
REQ-029 Watchdog: a 4-bit counter SHALL count FETCH/DRAIN cycles without ack and clear on ack or on leaving those states.
REQ-030 Watchdog expiry: when the count reaches MAX_WAIT, fault<=1 and the block goes to IDLE with imem_req=0; fault holds until rst.
REQ-031 run deasserted SHALL NOT abort an outstanding request; the transfer completes and the instruction is still presented.

Reset
REQ-032 On rst=1, the next edge SHALL set state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instruction=8'h00, instr_pc=8'h00, fault=0, watchdog=0.
REQ-033 rst SHALL override all inputs, including mid-transfer; the ack of an abandoned request SHALL be ignored.

Structure
REQ-034 A shared package SHALL hold the state enum, RESET_PC, and the 4-bit opcode constants (MOVE to LI) shared with the decoder.
REQ-035 The watchdog SHALL be the one sub-module, fetch_watchdog (count, clear, expired).

Verification
REQ-036 Reset, then run=1, ack one cycle after each req, ready=1: fetches 00,01,02 SHALL be returned in order with matching instr_pc, one instruction per 3 cycles.
REQ-037 Backpressure: ready=0 for 5 cycles in HOLD: instruction and instr_pc SHALL be held stable and no new imem_req SHALL be issued.
REQ-038 Redirect to 8'h40 while a request is pending, ack 3 cycles later: the stale data SHALL be dropped and the next imem_addr SHALL be 8'h40.
REQ-039 pc=8'hFF, fetch completes: the next imem_addr SHALL be 8'h00.
REQ-040 No ack for 15 cycles: fault=1, imem_req=0, and the block SHALL stay in IDLE until rst.
